wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 27 ++
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bundle of FU result handshakes and register-file write ports for wb_arbiter.
// slave is the arbiter's view; master is the producer/consumer side.
interface wb_arbiter_if #(
    parameter int unsigned NUM_FUS      = 4,
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter int unsigned PREG_W       = 6,
    parameter int unsigned DATA_W       = 32
);
    logic [NUM_FUS-1:0]                     fu_valid;
    logic [NUM_FUS-1:0]                     fu_ready;
    logic [NUM_FUS-1:0][PREG_W-1:0]         fu_dst;
    logic [NUM_FUS-1:0][DATA_W-1:0]         fu_val;
    logic [NUM_WR_PORTS-1:0]                wr_en;
    logic [NUM_WR_PORTS-1:0][PREG_W-1:0]    wr_dst;
    logic [NUM_WR_PORTS-1:0][DATA_W-1:0]    wr_val;
    logic                                   idle;

    modport master (
        output fu_valid, fu_dst, fu_val,
        input  fu_ready, wr_en, wr_dst, wr_val, idle
    );

    modport slave (
        input  fu_valid, fu_dst, fu_val,
        output fu_ready, wr_en, wr_dst, wr_val, idle
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin onto the
// register-file write ports, at most one entry per FU per cycle.
module wb_arbiter #(
    parameter int unsigned NUM_FUS      = 4,
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter int unsigned PREG_W       = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned Q_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned FU_W   = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
    localparam int unsigned PTR_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(Q_DEPTH + 1);
    localparam int unsigned PORT_W = (NUM_WR_PORTS > 1) ? $clog2(NUM_WR_PORTS) : 1;
    localparam int unsigned GNT_W  = $clog2(NUM_WR_PORTS + 1);

    logic [PREG_W-1:0] dst_mem_q [NUM_FUS][Q_DEPTH];
    logic [PREG_W-1:0] dst_mem_d [NUM_FUS][Q_DEPTH];
    logic [DATA_W-1:0] val_mem_q [NUM_FUS][Q_DEPTH];
    logic [DATA_W-1:0] val_mem_d [NUM_FUS][Q_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_FUS];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_FUS];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_FUS];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_FUS];
    logic [CNT_W-1:0]  cnt_q [NUM_FUS];
    logic [CNT_W-1:0]  cnt_d [NUM_FUS];
    logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_WR_PORTS-1:0]             wr_en_q, wr_en_d;
    logic [NUM_WR_PORTS-1:0][PREG_W-1:0] wr_dst_q, wr_dst_d;
    logic [NUM_WR_PORTS-1:0][DATA_W-1:0] wr_val_q, wr_val_d;

    logic [NUM_FUS-1:0] ready_c;
    logic [NUM_FUS-1:0] push;
    logic [NUM_FUS-1:0] pop;
    logic               all_empty;
    logic [GNT_W-1:0]   n_gnt;
    logic [FU_W-1:0]    scan_idx;
    int unsigned        scan_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(Q_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Ready reflects start-of-cycle occupancy only; a pop this cycle does not free a slot.
    always_comb begin
        ready_c   = '0;
        all_empty = 1'b1;
        for (int i = 0; i < NUM_FUS; i++) begin
            ready_c[i] = (cnt_q[i] < CNT_W'(Q_DEPTH));
            if (cnt_q[i] != '0) all_empty = 1'b0;
        end
    end

    // Round-robin scan from rr_ptr; k-th non-empty queue goes to port k.
    always_comb begin
        pop      = '0;
        wr_en_d  = '0;
        wr_dst_d = '0;
        wr_val_d = '0;
        rr_ptr_d = rr_ptr_q;
        n_gnt    = '0;
        scan_idx = '0;
        scan_sum = 0;
        for (int unsigned k = 0; k < NUM_FUS; k++) begin
            scan_sum = 32'(rr_ptr_q) + k;
            if (scan_sum >= NUM_FUS) scan_sum = scan_sum - NUM_FUS;
            scan_idx = FU_W'(scan_sum);
            if ((cnt_q[scan_idx] != '0) && (n_gnt < GNT_W'(NUM_WR_PORTS))) begin
                pop[scan_idx] = 1'b1;
                // A zero destination is consumed but never written.
                wr_en_d[n_gnt[PORT_W-1:0]]  = (dst_mem_q[scan_idx][rd_ptr_q[scan_idx]] != '0);
                wr_dst_d[n_gnt[PORT_W-1:0]] = dst_mem_q[scan_idx][rd_ptr_q[scan_idx]];
                wr_val_d[n_gnt[PORT_W-1:0]] = val_mem_q[scan_idx][rd_ptr_q[scan_idx]];
                n_gnt    = n_gnt + GNT_W'(1);
                rr_ptr_d = (scan_sum == NUM_FUS - 1) ? '0 : FU_W'(scan_sum + 1);
            end
        end
    end

    // Queue bookkeeping: push on handshake, pop on grant, both may coincide.
    always_comb begin
        push      = bus.fu_valid & ready_c;
        dst_mem_d = dst_mem_q;
        val_mem_d = val_mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < NUM_FUS; i++) begin
            if (push[i]) begin
                dst_mem_d[i][wr_ptr_q[i]] = bus.fu_dst[i];
                val_mem_d[i][wr_ptr_q[i]] = bus.fu_val[i];
                wr_ptr_d[i]               = ptr_inc(wr_ptr_q[i]);
            end
            if (pop[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FUS; i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
            rr_ptr_q <= '0;
            wr_en_q  <= '0;
            wr_dst_q <= '0;
            wr_val_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            wr_dst_q <= wr_dst_d;
            wr_val_q <= wr_val_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters alone.
    always_ff @(posedge clk) begin
        dst_mem_q <= dst_mem_d;
        val_mem_q <= val_mem_d;
    end

    assign bus.fu_ready = ready_c;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_dst   = wr_dst_q;
    assign bus.wr_val   = wr_val_q;
    assign bus.idle     = all_empty && (wr_en_q == '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, then queue-model driven
// backpressure and random traffic with order, loss and grant-latency checks.
module tb_wb_arbiter;
    localparam int NF = 4;
    localparam int NP = 2;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_FUS(NF), .NUM_WR_PORTS(NP), .PREG_W(6), .DATA_W(32)) bus ();

    wb_arbiter #(.NUM_FUS(NF), .NUM_WR_PORTS(NP), .PREG_W(6), .DATA_W(32), .Q_DEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic             r;
        logic [3:0]       v;
        logic [3:0][5:0]  d;
        logic [3:0][31:0] x;
        logic [1:0]       en;
        logic [1:0][5:0]  ed;
        logic [1:0][31:0] ev;
        logic [3:0]       rdy;
        logic             idl;
    } vec_t;

    typedef struct packed {
        logic [5:0]  dst;
        logic [31:0] val;
    } ent_t;

    int total = 0;
    int bad   = 0;

    vec_t tv [21];
    ent_t mq [NF][$];
    int   rr_m = 0;
    int   sb_next [NF];
    int   waitc   [NF];
    int   maxw    [NF];
    int   seq     [NF];
    logic [3:0]       hold;
    logic [3:0][5:0]  hd;
    logic [3:0][31:0] hx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0][5:0] d,
                                input logic [3:0][31:0] x, input logic [1:0] en,
                                input logic [1:0][5:0] ed, input logic [1:0][31:0] ev,
                                input logic [3:0] rdy, input logic idl);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.x = x; t.en = en; t.ed = ed; t.ev = ev;
        t.rdy = rdy; t.idl = idl;
        return t;
    endfunction

    task automatic apply_vec(input int k);
        @(negedge clk);
        rst          = tv[k].r;
        bus.fu_valid = tv[k].v;
        bus.fu_dst   = tv[k].d;
        bus.fu_val   = tv[k].x;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_wr_en", k), 64'(bus.wr_en), 64'(tv[k].en));
        for (int p = 0; p < NP; p++) begin
            if (tv[k].en[p]) begin
                chk($sformatf("v%0d_wr_dst%0d", k, p), 64'(bus.wr_dst[p]), 64'(tv[k].ed[p]));
                chk($sformatf("v%0d_wr_val%0d", k, p), 64'(bus.wr_val[p]), 64'(tv[k].ev[p]));
            end
        end
        chk($sformatf("v%0d_ready", k), 64'(bus.fu_ready), 64'(tv[k].rdy));
        chk($sformatf("v%0d_idle", k), 64'(bus.idle), 64'(tv[k].idl));
    endtask

    // One clock of the queue-level reference model against the DUT.
    task automatic mstep(input logic r, input logic [3:0] v, input logic [3:0][5:0] d,
                         input logic [3:0][31:0] x, output logic [3:0] acc);
        logic [3:0]       rdy_m, busy_m, seen, rdy_post;
        logic [1:0]       en_m;
        logic [1:0][5:0]  dst_m;
        logic [1:0][31:0] val_m;
        logic             all_e;
        logic [3:0]       tag;
        int               n, last, idx;
        ent_t             e;
        @(negedge clk);
        rst          = r;
        bus.fu_valid = v;
        bus.fu_dst   = d;
        bus.fu_val   = x;
        en_m = '0; dst_m = '0; val_m = '0; acc = '0; n = 0; last = -1;
        for (int i = 0; i < NF; i++) begin
            rdy_m[i]  = (mq[i].size() < QD);
            busy_m[i] = (mq[i].size() != 0);
        end
        if (r) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            rr_m = 0;
        end else begin
            chk("ready_pre", 64'(bus.fu_ready), 64'(rdy_m));
            for (int k = 0; k < NF; k++) begin
                idx = (rr_m + k) % NF;
                if (mq[idx].size() > 0 && n < NP) begin
                    e = mq[idx].pop_front();
                    en_m[n[0]]  = (e.dst != 6'd0);
                    dst_m[n[0]] = e.dst;
                    val_m[n[0]] = e.val;
                    n++;
                    last = idx;
                end
            end
            if (last >= 0) rr_m = (last + 1) % NF;
            for (int i = 0; i < NF; i++) begin
                if (v[i] && rdy_m[i]) begin
                    acc[i] = 1'b1;
                    e.dst  = d[i];
                    e.val  = x[i];
                    mq[i].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("wr_en", 64'(bus.wr_en), 64'(en_m));
        for (int p = 0; p < NP; p++) begin
            if (en_m[p]) begin
                chk($sformatf("wr_dst%0d", p), 64'(bus.wr_dst[p]), 64'(dst_m[p]));
                chk($sformatf("wr_val%0d", p), 64'(bus.wr_val[p]), 64'(val_m[p]));
            end
        end
        all_e = 1'b1;
        for (int i = 0; i < NF; i++) begin
            rdy_post[i] = (mq[i].size() < QD);
            if (mq[i].size() != 0) all_e = 1'b0;
        end
        chk("ready_post", 64'(bus.fu_ready), 64'(rdy_post));
        chk("idle", 64'(bus.idle), 64'(all_e && en_m == 2'b00));
        // Per-FU order and grant latency judged from what the DUT actually wrote.
        seen = '0;
        if (r) begin
            for (int i = 0; i < NF; i++) begin sb_next[i] = 0; waitc[i] = 0; end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (bus.wr_en[p]) begin
                    tag = bus.wr_val[p][31:28];
                    chk($sformatf("order_fu%0d", tag), 64'(bus.wr_val[p][27:0]),
                        64'(sb_next[tag[1:0]]));
                    sb_next[tag[1:0]]++;
                    seen[tag[1:0]] = 1'b1;
                end
            end
            for (int i = 0; i < NF; i++) begin
                if (busy_m[i] && !seen[i]) begin
                    waitc[i]++;
                    if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
                end else begin
                    waitc[i] = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        logic [3:0] acc;
        mstep(1'b1, 4'h0, '0, '0, acc);
        hold = '0;
        for (int i = 0; i < NF; i++) seq[i] = 0;
    endtask

    // Producers hold valid and data until accepted; values carry {fu, sequence}.
    task automatic traffic(input int cycles, input int pct, input logic [3:0] mask);
        logic [3:0] acc;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (!hold[i] && mask[i] && ($urandom_range(99) < 32'(pct))) begin
                    hold[i] = 1'b1;
                    hd[i]   = 6'($urandom_range(63, 1));
                    hx[i]   = {4'(i), 28'(seq[i])};
                end
            end
            mstep(1'b0, hold, hd, hx, acc);
            for (int i = 0; i < NF; i++) begin
                if (acc[i]) begin
                    hold[i] = 1'b0;
                    seq[i]++;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   fu1_left;
        logic saw_nr1;

        rst          = 1'b1;
        bus.fu_valid = '0;
        bus.fu_dst   = '0;
        bus.fu_val   = '0;
        hold         = '0;
        hd           = '0;
        hx           = '0;
        for (int i = 0; i < NF; i++) begin
            sb_next[i] = 0; waitc[i] = 0; maxw[i] = 0; seq[i] = 0;
        end

        tv[0]  = mk(1, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);
        tv[1]  = mk(0, 4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0},
                    2'b00, '0, '0, 4'hF, 0);
        tv[2]  = mk(0, 4'b0000, '0, '0, 2'b01, {6'd0, 6'd5}, {32'h0, 32'hDEADBEEF}, 4'hF, 0);
        tv[3]  = mk(0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);
        tv[4]  = mk(1, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);
        tv[5]  = mk(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h103, 32'h102, 32'h101, 32'h100},
                    2'b00, '0, '0, 4'hF, 0);
        tv[6]  = mk(0, 4'b0000, '0, '0, 2'b11, {6'd2, 6'd1}, {32'h101, 32'h100}, 4'hF, 0);
        tv[7]  = mk(0, 4'b0000, '0, '0, 2'b11, {6'd4, 6'd3}, {32'h103, 32'h102}, 4'hF, 0);
        tv[8]  = mk(0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);
        tv[9]  = mk(0, 4'b1001, {6'd10, 6'd0, 6'd0, 6'd9}, {32'hA3, 32'h0, 32'h0, 32'hA0},
                    2'b00, '0, '0, 4'hF, 0);
        tv[10] = mk(0, 4'b0000, '0, '0, 2'b11, {6'd10, 6'd9}, {32'hA3, 32'hA0}, 4'hF, 0);
        tv[11] = mk(0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);
        tv[12] = mk(0, 4'b0001, '0, {32'h0, 32'h0, 32'h0, 32'h11}, 2'b00, '0, '0, 4'hF, 0);
        tv[13] = mk(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd7}, {32'h0, 32'h0, 32'h0, 32'h22},
                    2'b00, '0, '0, 4'hF, 0);
        tv[14] = mk(0, 4'b0000, '0, '0, 2'b01, {6'd0, 6'd7}, {32'h0, 32'h22}, 4'hF, 0);
        tv[15] = mk(0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);
        tv[16] = mk(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h33, 32'h32, 32'h31, 32'h30},
                    2'b00, '0, '0, 4'hF, 0);
        tv[17] = mk(0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, {32'h43, 32'h42, 32'h41, 32'h40},
                    2'b11, {6'd3, 6'd2}, {32'h32, 32'h31}, 4'b0110, 0);
        tv[18] = mk(0, 4'b1111, {6'd12, 6'd11, 6'd10, 6'd9}, {32'h53, 32'h52, 32'h51, 32'h50},
                    2'b11, {6'd1, 6'd4}, {32'h30, 32'h33}, 4'b1001, 0);
        tv[19] = mk(1, 4'b1111, {6'd12, 6'd11, 6'd10, 6'd9}, {32'h63, 32'h62, 32'h61, 32'h60},
                    2'b00, '0, '0, 4'hF, 1);
        tv[20] = mk(0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'hF, 1);

        for (int k = 0; k < 21; k++) apply_vec(k);

        // FU1 sends three results while the other FUs keep their queues topped up.
        do_reset();
        fu1_left = 3;
        saw_nr1  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!hold[1] && fu1_left > 0) begin
                hold[1] = 1'b1;
                hd[1]   = 6'(20 + seq[1]);
                hx[1]   = {4'd1, 28'(seq[1])};
                fu1_left--;
            end
            traffic(1, 100, 4'b1101);
            if (!bus.fu_ready[1]) saw_nr1 = 1'b1;
        end
        traffic(12, 0, 4'b0000);
        chk("bp_fu1_ready_low", 64'(saw_nr1), 64'd1);
        chk("bp_fu1_written", 64'(sb_next[1]), 64'd3);
        chk("bp_fu1_accepted", 64'(seq[1]), 64'd3);
        chk("bp_drained_idle", 64'(bus.idle), 64'd1);

        // Random traffic at several load levels, then drain.
        do_reset();
        for (int i = 0; i < NF; i++) maxw[i] = 0;
        traffic(3000, 30, 4'hF);
        traffic(3000, 70, 4'hF);
        traffic(3000, 100, 4'hF);
        traffic(20, 0, 4'h0);
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("rand_count_fu%0d", i), 64'(sb_next[i]), 64'(seq[i]));
            chk($sformatf("rand_grant_wait_fu%0d", i), 64'(maxw[i] <= 1), 64'd1);
        end
        chk("rand_idle_end", 64'(bus.idle), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
